hw_output_stream_sink: RTL and testbench
========================================

// Module: hw_output_stream_sink
//
// PURPOSE
//   Synthesizable capture endpoint for an accelerator output stencil stream
//   (write_valid + write data).
//   - Stores accepted beats in an on-chip buffer, in arrival order.
//   - Counts beats against a configured expected length and flags done/overflow.
//   - Gives the host a registered random-access readback port.
//   - Sits at the accelerator top level in place of the simulation-only
//     output monitor, so output capture runs in silicon and on FPGA.
//
// PARAMETERS
//   DATA_W  16    width of one output stencil beat
//   DEPTH   1024  buffer entries; must be a power of two
//   ADDR_W  $clog2(DEPTH)  buffer address width (derived, do not override)
//
// PORTS
//   clk             in   1         single clock, all logic on posedge
//   rst_n           in   1         reset, synchronous, active-low
//   flush           in   1         start/restart capture (1-cycle pulse)
//   cfg_expected    in   ADDR_W+1  beats per frame; sampled on flush; 0 => DEPTH
//   wr_valid        in   1         beat present on wr_data this cycle
//   wr_data         in   DATA_W    output stencil beat
//   rd_en           in   1         host readback request
//   rd_addr         in   ADDR_W    host readback address
//   rd_data         out  DATA_W    readback data, 1 cycle after rd_en
//   rd_valid        out  1         rd_en delayed by 1 cycle
//   count           out  ADDR_W+1  beats accepted in the current frame
//   done            out  1         frame complete (count == expected)
//   overflow        out  1         sticky: beat arrived after done
//   checksum        out  32        running sum of accepted beats
//
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge):
//       - state=IDLE.
//       - rd_data, rd_valid, count, done, overflow and checksum all go to 0.
//       - Buffer contents are undefined.
//   - States: IDLE, CAPTURE, DONE, ERR.
//   - Priority per cycle: rst_n > flush > wr_valid.
//   - flush, from any state:
//       - next state=CAPTURE; count, done, overflow, checksum all cleared.
//       - exp_q <= (cfg_expected==0 ? DEPTH : cfg_expected); values above DEPTH
//         are clamped to DEPTH.
//       - A wr_valid in the same cycle is dropped.
//   - IDLE: wr_valid is ignored; no write, count unchanged.
//   - CAPTURE, on wr_valid:
//       - mem[count] <= wr_data; count <= count+1.
//       - If count+1 == exp_q: next state=DONE, and done=1 from the following cycle.
//   - DONE, on wr_valid: next state=ERR, overflow=1.
//       - The beat is not written and count holds.
//   - ERR: further wr_valid are ignored; overflow stays 1 until flush or reset.
//   - done stays 1 in DONE and ERR.
//   - Readback:
//       - Allowed in every state. rd_data <= mem[rd_addr] on rd_en;
//         rd_valid <= rd_en.
//       - rd_data holds its value when rd_en==0.
//       - Read and write to the same address in the same cycle returns the old
//         data (read-first).
//   - Reset mid-capture aborts the frame; after reset, count=0 and state=IDLE.
//   - No backpressure: the sink accepts one beat on every clock.
//   - Latency: wr_valid to count/done update is 1 cycle; rd_en to rd_data is
//     1 cycle.
//
// CONFIGURATION
//   HW_OUTPUT_SINK_CHECKSUM_EN
//     - Defined: checksum is a 32-bit wrapping sum of zero-extended beats that
//       were written to the buffer. Cleared on flush and reset.
//     - Undefined: the accumulator is not built and checksum is tied to 0.
//
// TESTING
//   T1 rst_n=0 2 cycles, wr_valid=1 with no flush
//        -> all outputs 0, count stays 0.
//   T2 flush with cfg_expected=4, then beats 10,11,12,13 back-to-back
//        -> done=1 the cycle after beat 13, count=4.
//        -> rd_addr 0..3 returns 10..13, rd_valid 1 cycle after rd_en.
//   T3 after T2, beat 99
//        -> overflow=1, count=4, mem[0] still reads 10.
//        -> then flush -> overflow=0, done=0, count=0.
//   T4 flush and wr_valid in the same cycle with data 7
//        -> count=0, mem[0] not written.
//        -> next beat 8 lands at address 0.
//   T5 DEPTH=8, cfg_expected=0, 8 beats; rst_n pulsed after 3 beats in a
//      second frame
//        -> done after 8 beats in the first frame.
//        -> after reset: state IDLE, count=0.
//   T6 with macro, beats 0xFFFF,0xFFFF -> checksum=0x0001FFFE.
//      Without macro -> checksum=0.

Source files
------------

// File: rtl/hw_output_stream_sink_if.sv
// Write-side stream of the output sink: one beat per cycle while wr_valid is high.
// The producer drives the master modport and the sink samples the slave modport.
interface hw_output_stream_sink_if #(
    parameter int unsigned DATA_W = 16
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, wr_data);
    modport slave  (input  wr_valid, wr_data);
endinterface

// File: rtl/hw_output_stream_sink.sv
// hw_output_stream_sink: captures an accelerator output stream into on-chip RAM and
// offers registered host readback. Define HW_OUTPUT_SINK_CHECKSUM_EN to build the checksum.
module hw_output_stream_sink #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [ADDR_W:0]       cfg_expected,
    hw_output_stream_sink_if.slave wr,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [ADDR_W:0]       count,
    output logic                  done,
    output logic                  overflow,
    output logic [31:0]           checksum
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_ERR} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   exp_q;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W:0]   exp_next;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    assign count_inc = count + {{ADDR_W{1'b0}}, 1'b1};
    assign exp_next  = (cfg_expected == '0 || cfg_expected > DEPTH_C) ? DEPTH_C : cfg_expected;
    assign wr_en     = rst_n && !flush && (state == S_CAPTURE) && wr.wr_valid;

    // Buffer has no reset; readback in the block below sees the pre-write value (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[ADDR_W-1:0]] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            exp_q    <= DEPTH_C;
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end

            if (flush) begin
                state    <= S_CAPTURE;
                exp_q    <= exp_next;
                count    <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else if (wr.wr_valid) begin
                case (state)
                    S_CAPTURE: begin
                        count <= count_inc;
                        if (count_inc == exp_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state    <= S_ERR;
                        overflow <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HW_OUTPUT_SINK_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            sum_q <= '0;
        end else if (wr_en) begin
            sum_q <= sum_q + 32'(wr.wr_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_hw_output_stream_sink.sv
// Bench for hw_output_stream_sink (DEPTH=8): readback checked through a queue scoreboard,
// status outputs checked inline by each scenario task.
module tb_hw_output_stream_sink;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef HW_OUTPUT_SINK_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [AW:0]   cfg_expected = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          done;
    logic          overflow;
    logic [31:0]   checksum;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            m_count = 0;
    int            m_exp = 0;
    bit            m_cap = 1'b0;

    hw_output_stream_sink_if #(.DATA_W(DW)) wr_if ();

    hw_output_stream_sink #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_expected(cfg_expected),
        .wr(wr_if), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .done(done), .overflow(overflow),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: rd_valid=1 with no read pending");
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    miscompares++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [AW:0] cfg);
        flush = 1'b1;
        cfg_expected = cfg;
        tick();
        flush = 1'b0;
        m_count = 0;
        m_exp = (cfg == 0 || cfg > DEPTH) ? DEPTH : int'(cfg);
        m_cap = 1'b1;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = d;
        if (m_cap && m_count < m_exp) begin
            model_mem[m_count] = d;
            m_count++;
        end
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1'b1;
        rd_addr = a;
        exp_q.push_back(model_mem[a]);
        tick();
        rd_en = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_valid_lat: got %b expected 1", rd_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 16'h1234;
        tick();
        tick();
        vectors++;
        if ({rd_data, rd_valid, count, done, overflow, checksum} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd_data=%0h rd_valid=%b count=%0d done=%b ovf=%b ck=%0h expected all 0",
                     rd_data, rd_valid, count, done, overflow, checksum);
        end
        rst_n = 1'b1;
        tick();
        tick();
        wr_if.wr_valid = 1'b0;
        vectors++;
        if (count !== 0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ignore: got count=%0d done=%b expected 0 0", count, done);
        end
    endtask

    task automatic test_capture();
        do_flush(4'd4);
        beat(16'd10);
        beat(16'd11);
        beat(16'd12);
        vectors++;
        if (done !== 1'b0 || count !== 4'd3) begin
            miscompares++;
            $display("FAIL pre_done: got done=%b count=%0d expected 0 3", done, count);
        end
        beat(16'd13);
        vectors++;
        if (done !== 1'b1 || count !== 4'd4) begin
            miscompares++;
            $display("FAIL done: got done=%b count=%0d expected 1 4", done, count);
        end
        vectors++;
        if (checksum !== (CK ? 32'd46 : 32'd0)) begin
            miscompares++;
            $display("FAIL checksum_frame: got %0h expected %0h", checksum, CK ? 32'd46 : 32'd0);
        end
        for (int i = 0; i < 4; i++) rd(AW'(i));
        tick();
    endtask

    task automatic test_overflow();
        beat(16'd99);
        vectors++;
        if (overflow !== 1'b1 || count !== 4'd4 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got ovf=%b count=%0d done=%b expected 1 4 1", overflow, count, done);
        end
        beat(16'd98);
        rd(3'd0);
        tick();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
        do_flush(4'd4);
        vectors++;
        if (overflow !== 1'b0 || done !== 1'b0 || count !== 0 || checksum !== 0) begin
            miscompares++;
            $display("FAIL flush_clear: got ovf=%b done=%b count=%0d ck=%0h expected 0 0 0 0",
                     overflow, done, count, checksum);
        end
    endtask

    task automatic test_flush_collision();
        flush = 1'b1;
        cfg_expected = 4'd4;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 16'd7;
        tick();
        flush = 1'b0;
        wr_if.wr_valid = 1'b0;
        m_count = 0;
        m_exp = 4;
        m_cap = 1'b1;
        vectors++;
        if (count !== 0) begin
            miscompares++;
            $display("FAIL flush_drop: got count=%0d expected 0", count);
        end
        rd(3'd0);
        beat(16'd8);
        rd(3'd0);
        tick();
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("FAIL after_drop: got count=%0d expected 1", count);
        end
    endtask

    task automatic test_full_depth();
        do_flush(4'd0);
        for (int i = 0; i < 7; i++) beat(DW'(20 + i));
        vectors++;
        if (done !== 1'b0 || count !== 4'd7) begin
            miscompares++;
            $display("FAIL depth_pre: got done=%b count=%0d expected 0 7", done, count);
        end
        beat(16'd27);
        vectors++;
        if (done !== 1'b1 || count !== 4'd8) begin
            miscompares++;
            $display("FAIL depth_done: got done=%b count=%0d expected 1 8", done, count);
        end
        for (int i = 0; i < 8; i++) rd(AW'(i));
        tick();
        do_flush(4'd0);
        beat(16'd30);
        beat(16'd31);
        beat(16'd32);
        rd(3'd2);
        rd(3'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_cap = 1'b0;
        m_count = 0;
        vectors++;
        if (count !== 0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: got count=%0d done=%b expected 0 0", count, done);
        end
        beat(16'd55);
        vectors++;
        if (count !== 0) begin
            miscompares++;
            $display("FAIL reset_idle: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_clamp();
        do_flush(4'd9);
        for (int i = 0; i < 7; i++) beat(DW'(40 + i));
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_pre: got done=%b expected 0", done);
        end
        beat(16'd47);
        vectors++;
        if (done !== 1'b1 || count !== 4'd8) begin
            miscompares++;
            $display("FAIL clamp_done: got done=%b count=%0d expected 1 8", done, count);
        end
        rd(3'd7);
        tick();
    endtask

    task automatic test_checksum();
        do_flush(4'd2);
        beat(16'hFFFF);
        beat(16'hFFFF);
        vectors++;
        if (checksum !== (CK ? 32'h0001_FFFE : 32'h0)) begin
            miscompares++;
            $display("FAIL checksum: got %0h expected %0h", checksum, CK ? 32'h0001_FFFE : 32'h0);
        end
        beat(16'd5);
        vectors++;
        if (checksum !== (CK ? 32'h0001_FFFE : 32'h0) || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL checksum_ovf: got ck=%0h ovf=%b expected %0h 1",
                     checksum, overflow, CK ? 32'h0001_FFFE : 32'h0);
        end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data = '0;
        test_reset();
        test_capture();
        test_overflow();
        test_flush_collision();
        test_full_depth();
        test_clamp();
        test_checksum();
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rd_drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
